// File: rtl/npcg_pm_pkg.sv
// Shared definitions for the NAND PCG primitive-module layer:
// command bus bit positions, option bits, bus widths and timer state encodings.
package npcg_pm_pkg;

  localparam int unsigned PCMD_W    = 8;
  localparam int unsigned PCMDOPT_W = 3;
  localparam int unsigned NUMDATA_W = 16;

  localparam int unsigned PCMD_TIMER = 0;
  localparam int unsigned PCMD_CAL   = 3;

  localparam int unsigned PCMDOPT_CE_HOLD = 0;

  localparam logic [3:0] TSTATE_RESET = 4'b0001;
  localparam logic [3:0] TSTATE_READY = 4'b0010;
  localparam logic [3:0] TSTATE_RUN   = 4'b0100;
  localparam logic [3:0] TSTATE_LAST  = 4'b1000;

endpackage

// File: rtl/npcg_toggle_timer_primitive.sv
// PM-layer timer lane: counts NumOfData+1 cycles, optionally holding CE low
// on the latched ways, then pulses oLastStep for one cycle.
module npcg_toggle_timer_primitive
  import npcg_pm_pkg::*;
#(
  parameter int NumberOfWays = 4
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic [PCMD_W-1:0]       iPCommand,
  input  logic [PCMDOPT_W-1:0]    iPCommandOption,
  input  logic [NumberOfWays-1:0] iTargetWay,
  input  logic [NUMDATA_W-1:0]    iNumOfData,
  output logic                    oReady,
  output logic                    oLastStep,
  output logic                    oBusy,
  output logic [NumberOfWays-1:0] oCE_n,
  output logic [NUMDATA_W-1:0]    oRemain
);

  logic [3:0]              state_q, state_d;
  logic [NUMDATA_W-1:0]    cnt_q, cnt_d;
  logic                    hold_ce_q, hold_ce_d;
  logic [NumberOfWays-1:0] way_q, way_d;

  logic ready, last_step, busy;

  // Only the timer bit and the CE-hold option bit are meaningful here.
  logic unused_inputs;
  assign unused_inputs = ^{iPCommand[PCMD_W-1:1], iPCommandOption[PCMDOPT_W-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_ce_d = hold_ce_q;
    way_d     = way_q;
    ready     = 1'b0;
    last_step = 1'b0;
    busy      = 1'b0;
    case (state_q)
      TSTATE_RESET: state_d = TSTATE_READY;
      TSTATE_READY: begin
        ready = 1'b1;
        if (iPCommand[PCMD_TIMER]) begin
          state_d   = TSTATE_RUN;
          cnt_d     = iNumOfData;
          hold_ce_d = iPCommandOption[PCMDOPT_CE_HOLD];
          way_d     = iTargetWay;
        end
      end
      TSTATE_RUN: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = TSTATE_LAST;
        else             cnt_d   = cnt_q - 16'd1;
      end
      TSTATE_LAST: begin
        busy      = 1'b1;
        last_step = 1'b1;
        state_d   = TSTATE_READY;
      end
      default: state_d = TSTATE_READY;
    endcase
  end

  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      state_q   <= TSTATE_RESET;
      cnt_q     <= '0;
      hold_ce_q <= 1'b0;
      way_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_ce_q <= hold_ce_d;
      way_q     <= way_d;
    end
  end

  // Outputs decode straight from the flops so a reset releases CE without a clock.
  assign oReady    = ready;
  assign oLastStep = last_step;
  assign oBusy     = busy;
  assign oCE_n     = ~(way_q & {NumberOfWays{hold_ce_q & busy}});
  assign oRemain   = cnt_q;

endmodule

// File: tb/tb_npcg_toggle_timer_primitive.sv
// Scoreboarded bench for the PM timer lane: expected oLastStep cycles are
// queued at each accepted start and matched by a free-running monitor.
module tb_npcg_toggle_timer_primitive;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd;
  logic [2:0]  opt;
  logic [3:0]  way;
  logic [15:0] nd;
  logic        ready, last_step, busy;
  logic [3:0]  ce_n;
  logic [15:0] remain;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_q[$];
  int unsigned mon_exp;
  int unsigned acc;

  npcg_toggle_timer_primitive #(.NumberOfWays(4)) dut (
    .iSystemClock    (clk),
    .iReset          (rst_n),
    .iPCommand       (cmd),
    .iPCommandOption (opt),
    .iTargetWay      (way),
    .iNumOfData      (nd),
    .oReady          (ready),
    .oLastStep       (last_step),
    .oBusy           (busy),
    .oCE_n           (ce_n),
    .oRemain         (remain)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every oLastStep pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (last_step === 1'b1) begin
      if (exp_q.size() == 0) mon_exp = 32'hFFFF_FFFF;
      else                   mon_exp = exp_q.pop_front();
      chk("laststep_cycle", cyc, mon_exp);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // Called at a negedge; waits (bounded) for oReady, issues a command, returns #1 after the accept edge.
  task automatic start(input logic [7:0] c, input logic [15:0] n, input logic [2:0] o,
                       input logic [3:0] w, input bit hold, output int unsigned a);
    int unsigned t = 0;
    while (ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (ready !== 1'b1) chk("ready_wait_timeout", 32'(ready), 32'd1);
    cmd = c; nd = n; opt = o; way = w;
    @(posedge clk);
    #1;
    a = cyc;
    exp_q.push_back(a + 32'(n) + 1);
    if (!hold) cmd = 8'h00;
  endtask

  task automatic run_check(input logic [15:0] n, input logic [2:0] o, input logic [3:0] w,
                           input bit mess);
    logic [3:0] ce_e;
    ce_e = o[0] ? ~w : 4'hF;
    for (int unsigned k = 0; k <= 32'(n) + 2; k++) begin
      @(negedge clk);
      if (k <= 32'(n) + 1) begin
        chk("run_ce_n", 32'(ce_n), 32'(ce_e));
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_ready", 32'(ready), 32'd0);
        chk("run_remain", 32'(remain), (k <= 32'(n)) ? 32'(n) - k : 32'd0);
      end else begin
        chk("done_ready", 32'(ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_ce_n", 32'(ce_n), 32'hF);
      end
      if (mess && k == 3) begin
        nd = 16'd5; way = 4'hF; cmd = 8'h00;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd = '0; opt = '0; way = '0; nd = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_last", 32'(last_step), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ce_n", 32'(ce_n), 32'hF);
    chk("rst_remain", 32'(remain), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);

    // Plain run with CE hold on way 1.
    start(8'h01, 16'd99, 3'b001, 4'b0010, 1'b0, acc);
    run_check(16'd99, 3'b001, 4'b0010, 1'b0);

    // Shortest run, no CE hold, upper command bits set.
    start(8'hFF, 16'd0, 3'b000, 4'b0011, 1'b0, acc);
    run_check(16'd0, 3'b000, 4'b0011, 1'b0);

    // No target way selected; option bits 2:1 set.
    start(8'h01, 16'd2, 3'b111, 4'b0000, 1'b0, acc);
    run_check(16'd2, 3'b111, 4'b0000, 1'b0);

    // Init-style loop: command held, 10 back-to-back runs of 100 cycles.
    start(8'h01, 16'd99, 3'b001, 4'b0001, 1'b1, acc);
    for (int unsigned i = 1; i < 10; i++) exp_q.push_back(acc + i * 102 + 100);
    for (int unsigned j = 0; j < 1020; j++) begin
      @(negedge clk);
      chk("loop_ce_n", 32'(ce_n), ((j % 102) <= 100) ? 32'hE : 32'hF);
      if (j == 1019) cmd = 8'h00;
    end
    @(negedge clk);
    chk("loop_end_busy", 32'(busy), 32'd0);
    chk("loop_end_ready", 32'(ready), 32'd1);

    // Mid-run changes to every input are ignored; no restart afterwards.
    start(8'h01, 16'd20, 3'b001, 4'b0101, 1'b1, acc);
    run_check(16'd20, 3'b001, 4'b0101, 1'b1);
    repeat (2) @(negedge clk);
    chk("no_restart_busy", 32'(busy), 32'd0);
    chk("no_restart_ready", 32'(ready), 32'd1);

    // Asynchronous reset at RUN cycle 40, start held across the release.
    start(8'h01, 16'd99, 3'b001, 4'b0100, 1'b0, acc);
    for (int unsigned k = 0; k <= 40; k++) @(negedge clk);
    chk("pre_abort_ce_n", 32'(ce_n), 32'hB);
    rst_n = 1'b0;
    #1;
    chk("abort_ce_n", 32'(ce_n), 32'hF);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_last", 32'(last_step), 32'd0);
    chk("abort_remain", 32'(remain), 32'd0);
    exp_q.delete();
    cmd = 8'h01; nd = 16'd3; opt = 3'b001; way = 4'b1000;
    repeat (2) @(negedge clk);
    chk("held_rst_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready", 32'(ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
    start(8'h01, 16'd3, 3'b001, 4'b1000, 1'b0, acc);
    run_check(16'd3, 3'b001, 4'b1000, 1'b0);

    // CAL-only command must not start the timer.
    cmd = 8'h08;
    for (int unsigned k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("cal_ready", 32'(ready), 32'd1);
      chk("cal_busy", 32'(busy), 32'd0);
      chk("cal_last", 32'(last_step), 32'd0);
    end
    cmd = 8'h00;

    @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
